// File: rtl/wired_tl_a_arbiter.sv
// wired_tl_a_arbiter: merges two TileLink channel-A hosts (host 0 = DCache,
// host 1 = ICache) onto one core-level A port with round-robin arbitration,
// keeping multi-beat messages contiguous, and steers channel-D beats back to
// the owning host by source ID.
// Optional feature macro: WIRED_TL_ARB_OUTBUF_EN inserts a two-entry skid
// buffer between the arbiter mux and o_a_* (one extra cycle of A latency).
module wired_tl_a_arbiter #(
    parameter int DATA_WIDTH   = 128,
    parameter int SOURCE_WIDTH = 1,
    parameter int HOST0_SOURCE = 0,
    parameter int A_PAYLOAD_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // host 0 channel A
    input  logic                     h0_a_valid,
    output logic                     h0_a_ready,
    input  logic [2:0]               h0_a_opcode,
    input  logic [3:0]               h0_a_size,
    input  logic [SOURCE_WIDTH-1:0]  h0_a_source,
    input  logic [DATA_WIDTH-1:0]    h0_a_data,
    input  logic [A_PAYLOAD_W-1:0]   h0_a_payload,
    // host 1 channel A
    input  logic                     h1_a_valid,
    output logic                     h1_a_ready,
    input  logic [2:0]               h1_a_opcode,
    input  logic [3:0]               h1_a_size,
    input  logic [SOURCE_WIDTH-1:0]  h1_a_source,
    input  logic [DATA_WIDTH-1:0]    h1_a_data,
    input  logic [A_PAYLOAD_W-1:0]   h1_a_payload,
    // merged channel A
    output logic                     o_a_valid,
    input  logic                     o_a_ready,
    output logic [2:0]               o_a_opcode,
    output logic [3:0]               o_a_size,
    output logic [SOURCE_WIDTH-1:0]  o_a_source,
    output logic [DATA_WIDTH-1:0]    o_a_data,
    output logic [A_PAYLOAD_W-1:0]   o_a_payload,
    // shared channel D
    input  logic                     o_d_valid,
    output logic                     o_d_ready,
    input  logic [SOURCE_WIDTH-1:0]  o_d_source,
    input  logic [DATA_WIDTH+15:0]   o_d_bits,
    // per-host channel D
    output logic                     h0_d_valid,
    input  logic                     h0_d_ready,
    output logic [DATA_WIDTH+15:0]   h0_d_bits,
    output logic                     h1_d_valid,
    input  logic                     h1_d_ready,
    output logic [DATA_WIDTH+15:0]   h1_d_bits
);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int LOG2_BYTES = $clog2(DATA_BYTES);
    localparam int BITS_W     = 3 + 4 + SOURCE_WIDTH + DATA_WIDTH + A_PAYLOAD_W;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic       owner_q, owner_d;
    logic [7:0] left_q, left_d;

    logic [1:0]        a_valid;
    logic [BITS_W-1:0] a_bits [2];
    logic              gnt;
    logic              gnt_active;
    logic              arb_valid;
    logic              arb_ready;
    logic              arb_fire;
    logic [BITS_W-1:0] arb_bits;
    logic [2:0]        arb_opcode;
    logic [3:0]        arb_size;
    logic [3:0]        shamt;
    logic [7:0]        first_beats;
    logic              out_valid;
    logic [BITS_W-1:0] out_bits;

    assign a_valid  = {h1_a_valid, h0_a_valid};
    assign a_bits[0] = {h0_a_opcode, h0_a_size, h0_a_source, h0_a_data, h0_a_payload};
    assign a_bits[1] = {h1_a_opcode, h1_a_size, h1_a_source, h1_a_data, h1_a_payload};

    // Grant: burst owner is locked in; in IDLE the preferred host wins a tie.
    always_comb begin
        gnt        = owner_q;
        gnt_active = 1'b1;
        if (state_q == IDLE) begin
            gnt_active = |a_valid;
            gnt        = (&a_valid) ? rr_q : a_valid[1];
        end
    end

    assign arb_valid  = gnt_active & a_valid[gnt];
    assign arb_bits   = a_bits[gnt];
    assign arb_fire   = arb_valid & arb_ready;
    assign arb_opcode = arb_bits[BITS_W-1 -: 3];
    assign arb_size   = arb_bits[BITS_W-4 -: 4];
    assign h0_a_ready = gnt_active & ~gnt & arb_ready;
    assign h1_a_ready = gnt_active &  gnt & arb_ready;

    // Beat count of the message whose first beat is on the mux now.
    always_comb begin
        shamt       = arb_size - 4'(LOG2_BYTES);
        first_beats = 8'd1;
        if (!arb_opcode[2] && (arb_size > 4'(LOG2_BYTES))) begin
            first_beats = 8'd1 << shamt;
        end
    end

    // Next-state: single-beat messages rotate priority, longer ones lock a burst.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        left_d  = left_q;
        case (state_q)
            IDLE: begin
                if (arb_fire) begin
                    if (first_beats == 8'd1) begin
                        rr_d = ~gnt;
                    end else begin
                        state_d = BURST;
                        owner_d = gnt;
                        left_d  = first_beats - 8'd1;
                    end
                end
            end
            BURST: begin
                if (arb_fire) begin
                    left_d = left_q - 8'd1;
                    if (left_q == 8'd1) begin
                        state_d = IDLE;
                        rr_d    = ~owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            owner_q <= 1'b0;
            left_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            left_q  <= left_d;
        end
    end

    // Flag first beats whose size would overflow the 8-bit beat counter.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == IDLE) && arb_fire && !arb_opcode[2]) begin
            assert (arb_size <= 4'(LOG2_BYTES + 7));
        end
    end

`ifdef WIRED_TL_ARB_OUTBUF_EN
    logic [BITS_W-1:0] buf_mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              buf_pop;

    assign arb_ready = (cnt_q != 2'd2);
    assign out_valid = (cnt_q != 2'd0);
    assign out_bits  = buf_mem_q[rd_ptr_q];
    assign buf_pop   = out_valid & o_a_ready;

    // Skid-buffer pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q ^ arb_fire;
        rd_ptr_d = rd_ptr_q ^ buf_pop;
        cnt_d    = cnt_q + 2'(arb_fire) - 2'(buf_pop);
    end

    // Occupancy registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Buffer storage: written on every accepted arbiter beat.
    always_ff @(posedge clk) begin
        if (arb_fire) begin
            buf_mem_q[wr_ptr_q] <= arb_bits;
        end
    end
`else
    assign arb_ready = o_a_ready;
    assign out_valid = arb_valid;
    assign out_bits  = arb_bits;
`endif

    assign o_a_valid = out_valid;
    assign {o_a_opcode, o_a_size, o_a_source, o_a_data, o_a_payload} = out_bits;

    // D routing is stateless: the source ID picks the host for each beat.
    logic d_sel;
    assign d_sel      = (o_d_source != SOURCE_WIDTH'(HOST0_SOURCE));
    assign h0_d_valid = o_d_valid & ~d_sel;
    assign h1_d_valid = o_d_valid &  d_sel;
    assign o_d_ready  = d_sel ? h1_d_ready : h0_d_ready;
    assign h0_d_bits  = o_d_bits;
    assign h1_d_bits  = o_d_bits;
endmodule

// File: tb/tb_wired_tl_a_arbiter.sv
// Testbench for wired_tl_a_arbiter: directed scenarios plus a randomized
// phase checked against a message-level reference model (alternating
// messages from two always-requesting hosts, beat counts from opcode/size).
module tb_wired_tl_a_arbiter;
    localparam int DW  = 128;
    localparam int SW  = 1;
    localparam int PW  = 64;
    localparam int DBW = DW + 16;
`ifdef WIRED_TL_ARB_OUTBUF_EN
    localparam int A_LAT = 1;
`else
    localparam int A_LAT = 0;
`endif

    logic clk, rst_n;
    logic h0_a_valid, h0_a_ready, h1_a_valid, h1_a_ready;
    logic [2:0] h0_a_opcode, h1_a_opcode, o_a_opcode;
    logic [3:0] h0_a_size, h1_a_size, o_a_size;
    logic [SW-1:0] h0_a_source, h1_a_source, o_a_source, o_d_source;
    logic [DW-1:0] h0_a_data, h1_a_data, o_a_data;
    logic [PW-1:0] h0_a_payload, h1_a_payload, o_a_payload;
    logic o_a_valid, o_a_ready;
    logic o_d_valid, o_d_ready, h0_d_valid, h0_d_ready, h1_d_valid, h1_d_ready;
    logic [DBW-1:0] o_d_bits, h0_d_bits, h1_d_bits;

    wired_tl_a_arbiter #(.DATA_WIDTH(DW), .SOURCE_WIDTH(SW), .HOST0_SOURCE(0), .A_PAYLOAD_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .h0_a_valid(h0_a_valid), .h0_a_ready(h0_a_ready), .h0_a_opcode(h0_a_opcode),
        .h0_a_size(h0_a_size), .h0_a_source(h0_a_source), .h0_a_data(h0_a_data),
        .h0_a_payload(h0_a_payload),
        .h1_a_valid(h1_a_valid), .h1_a_ready(h1_a_ready), .h1_a_opcode(h1_a_opcode),
        .h1_a_size(h1_a_size), .h1_a_source(h1_a_source), .h1_a_data(h1_a_data),
        .h1_a_payload(h1_a_payload),
        .o_a_valid(o_a_valid), .o_a_ready(o_a_ready), .o_a_opcode(o_a_opcode),
        .o_a_size(o_a_size), .o_a_source(o_a_source), .o_a_data(o_a_data),
        .o_a_payload(o_a_payload),
        .o_d_valid(o_d_valid), .o_d_ready(o_d_ready), .o_d_source(o_d_source),
        .o_d_bits(o_d_bits),
        .h0_d_valid(h0_d_valid), .h0_d_ready(h0_d_ready), .h0_d_bits(h0_d_bits),
        .h1_d_valid(h1_d_valid), .h1_d_ready(h1_d_ready), .h1_d_bits(h1_d_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    op;
        logic [3:0]    sz;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [PW-1:0] pl;
    } beat_t;

    beat_t hq0[$], hq1[$], exp_q[$];
    int    gnt_log[$];
    int    n_tests = 0, n_fail = 0;
    bit    sb_en = 1'b0, d_rand = 1'b1;
    logic  obs_o_valid, obs_h0_rdy, obs_h0_fire, obs_h1_fire, obs_od_ready;
    logic  obs_d0_fire, obs_d1_fire;
    int    o_fire_cnt = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Number of beats in a TL A message.
    function automatic int beats_of(input int op, input int sz);
        int b;
        if (op >= 4) return 1;
        b = (1 << sz) / (DW / 8);
        return (b < 1) ? 1 : b;
    endfunction

    // Queue one message on a host; non-first beats carry junk opcode/size.
    function automatic void add_msg(input int h, input int op, input int sz);
        beat_t b;
        int n;
        n = beats_of(op, sz);
        for (int i = 0; i < n; i++) begin
            b.op   = (i == 0) ? 3'(op) : 3'($urandom_range(0, 7));
            b.sz   = (i == 0) ? 4'(sz) : 4'($urandom_range(0, 7));
            b.src  = SW'(h);
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.pl   = {$urandom, $urandom};
            if (h == 0) hq0.push_back(b); else hq1.push_back(b);
        end
    endfunction

    // Expected merged order: whole messages alternate between hosts starting at p.
    function automatic void plan(input int p);
        int i0, i1, h, n;
        i0 = 0; i1 = 0;
        while (i0 < hq0.size() || i1 < hq1.size()) begin
            h = p;
            if (h == 0 && i0 >= hq0.size()) h = 1;
            else if (h == 1 && i1 >= hq1.size()) h = 0;
            if (h == 0) begin
                n = beats_of(int'(hq0[i0].op), int'(hq0[i0].sz));
                for (int k = 0; k < n; k++) exp_q.push_back(hq0[i0 + k]);
                i0 += n;
            end else begin
                n = beats_of(int'(hq1[i1].op), int'(hq1[i1].sz));
                for (int k = 0; k < n; k++) exp_q.push_back(hq1[i1 + k]);
                i1 += n;
            end
            p = 1 - h;
        end
    endfunction

    // One clock cycle: drive hosts from their queues, sample #1 later, check, advance.
    task automatic step();
        beat_t b0, b1;
        b0 = (hq0.size() != 0) ? hq0[0] : '0;
        b1 = (hq1.size() != 0) ? hq1[0] : '0;
        h0_a_valid = (hq0.size() != 0);
        h1_a_valid = (hq1.size() != 0);
        {h0_a_opcode, h0_a_size, h0_a_source, h0_a_data, h0_a_payload} = b0;
        {h1_a_opcode, h1_a_size, h1_a_source, h1_a_data, h1_a_payload} = b1;
        if (d_rand) begin
            o_d_valid  = 1'($urandom);
            o_d_source = SW'($urandom);
            o_d_bits   = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            h0_d_ready = 1'($urandom);
            h1_d_ready = 1'($urandom);
        end
        #1;
        obs_o_valid  = o_a_valid;
        obs_h0_rdy   = h0_a_ready;
        obs_h0_fire  = h0_a_valid & h0_a_ready;
        obs_h1_fire  = h1_a_valid & h1_a_ready;
        obs_od_ready = o_d_ready;
        obs_d0_fire  = h0_d_valid & h0_d_ready;
        obs_d1_fire  = h1_d_valid & h1_d_ready;
        chk("d0_valid", h0_d_valid, o_d_valid && (o_d_source == 0));
        chk("d1_valid", h1_d_valid, o_d_valid && (o_d_source != 0));
        chk("d_ready", o_d_ready, (o_d_source == 0) ? h0_d_ready : h1_d_ready);
        chk("d0_bits", h0_d_bits, o_d_bits);
        chk("d1_bits", h1_d_bits, o_d_bits);
        chk("a_ready_excl", h0_a_ready & h1_a_ready, 1'b0);
        if (o_a_valid && o_a_ready) begin
            o_fire_cnt++;
            if (sb_en) begin
                chk("sb_beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    chk("o_a_beat", {o_a_opcode, o_a_size, o_a_source, o_a_data, o_a_payload},
                        exp_q.pop_front());
            end
        end
        if (obs_h0_fire) void'(hq0.pop_front());
        if (obs_h1_fire) void'(hq1.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        hq0.delete(); hq1.delete(); exp_q.delete();
        sb_en = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
        sb_en = 1'b1;
    endtask

    task automatic drain();
        o_a_ready = 1'b1;
        repeat (3) step();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int dsrc[4];
        int dlog[$];
        int di, cyc, nb, n0, n1;
        dsrc = '{0, 1, 1, 0};
        rst_n = 1'b0; o_a_ready = 1'b0;
        o_d_valid = 1'b0; o_d_source = '0; o_d_bits = '0; h0_d_ready = 1'b0; h1_d_ready = 1'b0;
        @(negedge clk);
        do_reset(2);

        // Reset state with no host requesting.
        o_a_ready = 1'b1;
        step();
        chk("rst_o_a_valid", obs_o_valid, 1'b0);
        chk("rst_h0_ready", obs_h0_rdy, 1'b0);
        chk("rst_h1_ready", h1_a_ready, 1'b0);
        chk("rst_rr", dut.rr_q, 1'b0);
        chk("rst_left", dut.left_q, 8'd0);

        // Contention: both hosts offer single-beat Gets.
        add_msg(0, 4, 0); add_msg(1, 4, 0); add_msg(0, 4, 0); add_msg(1, 4, 0);
        plan(0);
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            step();
            gnt_log.push_back(obs_h1_fire ? 1 : (obs_h0_fire ? 0 : -1));
        end
        for (int i = 0; i < 4; i++) chk($sformatf("contention_gnt%0d", i), gnt_log[i], i % 2);
        chk("contention_done", hq0.size() + hq1.size(), 0);
        drain();

        // Single host-0 Get moves priority to host 1.
        add_msg(0, 4, 0); plan(0); step(); drain();

        // Burst lock: host-1 PutFullData of 4 beats vs a waiting host-0 Get.
        add_msg(1, 0, 6); add_msg(0, 4, 0); plan(1);
        gnt_log.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            gnt_log.push_back(obs_h1_fire ? 1 : (obs_h0_fire ? 0 : -1));
            if (i < 4) chk($sformatf("lock_h0_ready%0d", i), obs_h0_rdy, 1'b0);
        end
        for (int i = 0; i < 5; i++) chk($sformatf("lock_gnt%0d", i), gnt_log[i], (i < 4) ? 1 : 0);
        drain();

        // Back-pressure: o_a_ready toggles during a 4-beat burst.
        add_msg(0, 0, 6); plan(0);
        o_fire_cnt = 0; nb = 0;
        for (int i = 0; i < 40 && (hq0.size() != 0 || exp_q.size() != 0); i++) begin
            o_a_ready = (i % 2 == 0);
            step();
            if (obs_h0_fire) begin
                nb++;
                if (nb == 4) chk("bp_left_zero", dut.left_q, 8'd0);
            end
        end
        chk("bp_beats_out", o_fire_cnt, 4);
        chk("bp_all_out", exp_q.size(), 0);
        drain();

        // D routing with one stalled cycle on host 1.
        d_rand = 1'b0; di = 0; cyc = 0; dlog.delete();
        while (di < 4 && cyc < 10) begin
            o_d_valid  = 1'b1;
            o_d_source = SW'(dsrc[di]);
            o_d_bits   = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
            h0_d_ready = 1'b1;
            h1_d_ready = (cyc != 1);
            step();
            if (cyc == 1) chk("d_stall_ready", obs_od_ready, 1'b0);
            chk("d_no_dup", obs_d0_fire & obs_d1_fire, 1'b0);
            if (obs_d0_fire) begin dlog.push_back(0); di++; end
            else if (obs_d1_fire) begin dlog.push_back(1); di++; end
            cyc++;
        end
        chk("d_count", dlog.size(), 4);
        for (int i = 0; i < 4 && i < dlog.size(); i++) chk($sformatf("d_route%0d", i), dlog[i], dsrc[i]);
        chk("d_cycles", cyc, 5);
        o_d_valid = 1'b0; d_rand = 1'b1;

        // Reset in the middle of a burst.
        add_msg(0, 4, 0); plan(0); step(); drain();
        sb_en = 1'b0;
        add_msg(1, 0, 6);
        nb = 0;
        for (int i = 0; i < 10 && nb < 2; i++) begin
            step();
            if (obs_h1_fire) nb++;
        end
        chk("mid_burst_left", dut.left_q, 8'd2);
        do_reset(1);
        chk("post_rst_rr", dut.rr_q, 1'b0);
        chk("post_rst_left", dut.left_q, 8'd0);
        add_msg(0, 4, 0); add_msg(1, 4, 0); plan(0);
        step();
        chk("post_rst_h0_gnt", obs_h0_fire, 1'b1);
        chk("post_rst_h1_wait", obs_h1_fire, 1'b0);
        chk("post_rst_o_valid", obs_o_valid, (A_LAT == 0));
        drain();

        // A-path latency of a lone Get.
        add_msg(0, 4, 0); plan(0);
        step();
        chk("lat_fire", obs_h0_fire, 1'b1);
        chk("lat_same_cycle", obs_o_valid, (A_LAT == 0));
        step();
        chk("lat_next_cycle", obs_o_valid, (A_LAT == 1));
        drain();

        // Randomized traffic with random back-pressure and D traffic.
        do_reset(2);
        n0 = $urandom_range(8, 14); n1 = $urandom_range(8, 14);
        for (int i = 0; i < n0; i++) add_msg(0, $urandom_range(0, 7), $urandom_range(0, 7));
        for (int i = 0; i < n1; i++) add_msg(1, $urandom_range(0, 7), $urandom_range(0, 7));
        plan(0);
        for (int i = 0; i < 3000 && (hq0.size() + hq1.size() + exp_q.size()) != 0; i++) begin
            o_a_ready = ($urandom % 4) != 0;
            step();
        end
        chk("rand_hosts_done", hq0.size() + hq1.size(), 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
